// File: rtl/eco32f_wb_arbiter_pkg.sv
// Shared types and constants for the eco32f Wishbone arbiter.
package eco32f_wb_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GNT_I = 2'd1,
        ARB_GNT_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // Round-robin choice when both requesters ask at once.
    function automatic req_e rr_pick(input req_e last);
        return (last == REQ_I) ? REQ_D : REQ_I;
    endfunction

endpackage

// File: rtl/eco32f_wb_arb_timeout.sv
// Bus watchdog for eco32f_wb_arbiter; only present when ECO32F_WB_ARB_TIMEOUT_EN is defined.
`ifdef ECO32F_WB_ARB_TIMEOUT_EN
module eco32f_wb_arb_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic ack_seen,
    input  logic stall,
    output logic fire,
    output logic kill
);

    localparam logic [15:0] Limit = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] count_q;
    logic        kill_q;

    // Fires on the stalled cycle that brings the count up to TIMEOUT_CYCLES.
    assign fire = stall && !kill_q && (count_q == Limit);
    assign kill = kill_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            kill_q  <= 1'b0;
        end else if (restart) begin
            count_q <= '0;
            kill_q  <= 1'b0;
        end else begin
            if (ack_seen) begin
                count_q <= '0;
            end else if (stall) begin
                count_q <= count_q + 16'd1;
            end
            if (fire) begin
                kill_q <= 1'b1;
            end
        end
    end

endmodule
`endif

// File: rtl/eco32f_wb_arbiter.sv
// Two-requester Wishbone B3 arbiter (ifetch / data) onto one master port.
// Optional watchdog enabled by ECO32F_WB_ARB_TIMEOUT_EN.
module eco32f_wb_arbiter
    import eco32f_wb_arbiter_pkg::*;
#(
    parameter int unsigned PRIO_MODE      = 0,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] iwb_adr_i,
    input  logic [31:0] iwb_dat_i,
    input  logic [3:0]  iwb_sel_i,
    input  logic        iwb_we_i,
    input  logic [2:0]  iwb_cti_i,
    input  logic [1:0]  iwb_bte_i,
    input  logic        iwb_cyc_i,
    input  logic        iwb_stb_i,
    output logic [31:0] iwb_dat_o,
    output logic        iwb_ack_o,
    output logic        iwb_err_o,
    output logic        iwb_rty_o,
    input  logic [31:0] dwb_adr_i,
    input  logic [31:0] dwb_dat_i,
    input  logic [3:0]  dwb_sel_i,
    input  logic        dwb_we_i,
    input  logic [2:0]  dwb_cti_i,
    input  logic [1:0]  dwb_bte_i,
    input  logic        dwb_cyc_i,
    input  logic        dwb_stb_i,
    output logic [31:0] dwb_dat_o,
    output logic        dwb_ack_o,
    output logic        dwb_err_o,
    output logic        dwb_rty_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic [2:0]  wbm_cti_o,
    output logic [1:0]  wbm_bte_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic        wbm_rty_i
);

    arb_state_e state_q, state_d;
    req_e       last_q;
    logic       fire, kill;
    logic       gnt_i, gnt_d, live_i, live_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: begin
                if (iwb_cyc_i && dwb_cyc_i) begin
                    state_d = (PRIO_MODE == 1 || rr_pick(last_q) == REQ_D) ? ARB_GNT_D
                                                                           : ARB_GNT_I;
                end else if (iwb_cyc_i) begin
                    state_d = ARB_GNT_I;
                end else if (dwb_cyc_i) begin
                    state_d = ARB_GNT_D;
                end
            end
            ARB_GNT_I: if (!iwb_cyc_i) state_d = dwb_cyc_i ? ARB_GNT_D : ARB_IDLE;
            ARB_GNT_D: if (!dwb_cyc_i) state_d = iwb_cyc_i ? ARB_GNT_I : ARB_IDLE;
            default:   state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB_IDLE;
            last_q  <= REQ_I;
        end else begin
            state_q <= state_d;
            if (state_q == ARB_GNT_I) last_q <= REQ_I;
            if (state_q == ARB_GNT_D) last_q <= REQ_D;
        end
    end

    assign gnt_i = (state_q == ARB_GNT_I);
    assign gnt_d = (state_q == ARB_GNT_D);

    // Idle mirrors the data bus; reset forces the whole master port quiet.
    always_comb begin
        wbm_adr_o = dwb_adr_i;
        wbm_dat_o = dwb_dat_i;
        wbm_sel_o = dwb_sel_i;
        wbm_we_o  = dwb_we_i;
        wbm_cti_o = dwb_cti_i;
        wbm_bte_o = dwb_bte_i;
        wbm_cyc_o = 1'b0;
        wbm_stb_o = 1'b0;
        case (state_q)
            ARB_GNT_I: begin
                wbm_adr_o = iwb_adr_i;
                wbm_dat_o = iwb_dat_i;
                wbm_sel_o = iwb_sel_i;
                wbm_we_o  = iwb_we_i;
                wbm_cti_o = iwb_cti_i;
                wbm_bte_o = iwb_bte_i;
                wbm_cyc_o = iwb_cyc_i & ~kill;
                wbm_stb_o = iwb_cyc_i & iwb_stb_i & ~kill;
            end
            ARB_GNT_D: begin
                wbm_cyc_o = dwb_cyc_i & ~kill;
                wbm_stb_o = dwb_cyc_i & dwb_stb_i & ~kill;
            end
            default: ;
        endcase
        if (!rst) begin
            wbm_adr_o = '0;
            wbm_dat_o = '0;
            wbm_sel_o = '0;
            wbm_we_o  = 1'b0;
            wbm_cti_o = '0;
            wbm_bte_o = '0;
            wbm_cyc_o = 1'b0;
            wbm_stb_o = 1'b0;
        end
    end

    // A requester that dropped cyc has abandoned its cycle and gets nothing back.
    assign live_i    = gnt_i & iwb_cyc_i & ~kill;
    assign live_d    = gnt_d & dwb_cyc_i & ~kill;
    assign iwb_dat_o = wbm_dat_i;
    assign dwb_dat_o = wbm_dat_i;
    assign iwb_ack_o = live_i & wbm_ack_i;
    assign iwb_rty_o = live_i & wbm_rty_i;
    assign iwb_err_o = (live_i & wbm_err_i) | (gnt_i & fire);
    assign dwb_ack_o = live_d & wbm_ack_i;
    assign dwb_rty_o = live_d & wbm_rty_i;
    assign dwb_err_o = (live_d & wbm_err_i) | (gnt_d & fire);

`ifdef ECO32F_WB_ARB_TIMEOUT_EN
    logic stall, restart, ack_fwd;

    assign stall   = wbm_stb_o & ~(wbm_ack_i | wbm_err_i | wbm_rty_i);
    assign restart = (state_d != state_q);
    assign ack_fwd = iwb_ack_o | dwb_ack_o;

    eco32f_wb_arb_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .restart  (restart),
        .ack_seen (ack_fwd),
        .stall    (stall),
        .fire     (fire),
        .kill     (kill)
    );
`else
    logic unused_timeout;

    assign fire           = 1'b0;
    assign kill           = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_eco32f_wb_arbiter.sv
// Bench for eco32f_wb_arbiter: a round-robin and a fixed-priority instance share stimulus.
module tb_eco32f_wb_arbiter;
    import eco32f_wb_arbiter_pkg::*;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        logic [2:0]  cti;
        logic [1:0]  bte;
        logic        cyc;
        logic        stb;
    } req_t;

    logic        clk = 1'b0;
    logic        rst_n;
    req_t        rq [2];  // 0 = ifetch, 1 = data
    logic [31:0] m_dat;
    logic        m_ack, m_err, m_rty;

    logic [31:0] idat [2], ddat [2], madr [2], mdat [2];
    logic        iack [2], ierr [2], irty [2], dack [2], derr [2], drty [2];
    logic [3:0]  msel [2];
    logic        mwe [2], mcyc [2], mstb [2];
    logic [2:0]  mcti [2];
    logic [1:0]  mbte [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        eco32f_wb_arbiter #(
            .PRIO_MODE      (g),
            .TIMEOUT_CYCLES (4)
        ) u_dut (
            .clk       (clk),
            .rst       (rst_n),
            .iwb_adr_i (rq[0].adr),
            .iwb_dat_i (rq[0].dat),
            .iwb_sel_i (rq[0].sel),
            .iwb_we_i  (rq[0].we),
            .iwb_cti_i (rq[0].cti),
            .iwb_bte_i (rq[0].bte),
            .iwb_cyc_i (rq[0].cyc),
            .iwb_stb_i (rq[0].stb),
            .iwb_dat_o (idat[g]),
            .iwb_ack_o (iack[g]),
            .iwb_err_o (ierr[g]),
            .iwb_rty_o (irty[g]),
            .dwb_adr_i (rq[1].adr),
            .dwb_dat_i (rq[1].dat),
            .dwb_sel_i (rq[1].sel),
            .dwb_we_i  (rq[1].we),
            .dwb_cti_i (rq[1].cti),
            .dwb_bte_i (rq[1].bte),
            .dwb_cyc_i (rq[1].cyc),
            .dwb_stb_i (rq[1].stb),
            .dwb_dat_o (ddat[g]),
            .dwb_ack_o (dack[g]),
            .dwb_err_o (derr[g]),
            .dwb_rty_o (drty[g]),
            .wbm_adr_o (madr[g]),
            .wbm_dat_o (mdat[g]),
            .wbm_sel_o (msel[g]),
            .wbm_we_o  (mwe[g]),
            .wbm_cti_o (mcti[g]),
            .wbm_bte_o (mbte[g]),
            .wbm_cyc_o (mcyc[g]),
            .wbm_stb_o (mstb[g]),
            .wbm_dat_i (m_dat),
            .wbm_ack_i (m_ack),
            .wbm_err_i (m_err),
            .wbm_rty_i (m_rty)
        );
    end

    function automatic logic [75:0] wbm_of(input int k);
        return {madr[k], mdat[k], msel[k], mwe[k], mcti[k], mbte[k], mcyc[k], mstb[k]};
    endfunction

    function automatic logic [5:0] rsp_of(input int k);
        return {iack[k], ierr[k], irty[k], dack[k], derr[k], drty[k]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        rq[0] = '0;
        rq[1] = '0;
        m_dat = '0;
        m_ack = 1'b0;
        m_err = 1'b0;
        m_rty = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rq[0] = '{adr: 32'h1111_1111, dat: 32'h2222_2222, sel: 4'hf, we: 1'b1,
                  cti: CTI_INCR, bte: 2'b10, cyc: 1'b1, stb: 1'b1};
        rq[1] = '{adr: 32'h3333_3333, dat: 32'h4444_4444, sel: 4'h5, we: 1'b1,
                  cti: CTI_EOB, bte: 2'b01, cyc: 1'b1, stb: 1'b1};
        m_ack = 1'b1; m_err = 1'b1; m_rty = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (wbm_of(k) !== 76'd0) begin
                    n_fail++;
                    $display("FAIL reset_wbm dut%0d: got %h want 0", k, wbm_of(k));
                end
                n_checks++;
                if (rsp_of(k) !== 6'd0) begin
                    n_fail++;
                    $display("FAIL reset_rsp dut%0d: got %b want 000000", k, rsp_of(k));
                end
            end
        end
        idle_all();
        rq[1].adr = 32'h0bad_cafe;
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (mcyc[k] !== 1'b0 || madr[k] !== 32'h0bad_cafe) begin
                n_fail++;
                $display("FAIL idle_mirror dut%0d: got cyc=%b adr=%h want cyc=0 adr=0badcafe",
                         k, mcyc[k], madr[k]);
            end
        end
        tick();
    endtask

    // From reset last grant is I, so round-robin serves D, I, D, I; fixed priority always D.
    task automatic test_round_robin();
        for (int r = 0; r < 4; r++) begin
            rq[0] = '{adr: 32'h1000_0000 + r, dat: 32'h0, sel: 4'hf, we: 1'b0,
                      cti: CTI_CLASSIC, bte: 2'b00, cyc: 1'b1, stb: 1'b1};
            rq[1] = '{adr: 32'h2000_0000 + r, dat: 32'h0, sel: 4'hf, we: 1'b0,
                      cti: CTI_CLASSIC, bte: 2'b00, cyc: 1'b1, stb: 1'b1};
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (mcyc[k] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rr_latency dut%0d: got cyc=%b want 0", k, mcyc[k]);
                end
            end
            tick();
            m_ack = 1'b1;
            m_dat = 32'hface_0000 + r;
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                logic        want_d;
                logic [31:0] want_adr;
                want_d   = (k == 1) || (r % 2 == 0);
                want_adr = want_d ? rq[1].adr : rq[0].adr;
                n_checks++;
                if (mcyc[k] !== 1'b1 || madr[k] !== want_adr) begin
                    n_fail++;
                    $display("FAIL rr_grant dut%0d round %0d: got cyc=%b adr=%h want cyc=1 adr=%h",
                             k, r, mcyc[k], madr[k], want_adr);
                end
                n_checks++;
                if (dack[k] !== want_d || iack[k] !== !want_d) begin
                    n_fail++;
                    $display("FAIL rr_ack dut%0d round %0d: got i=%b d=%b want i=%b d=%b",
                             k, r, iack[k], dack[k], !want_d, want_d);
                end
            end
            tick();
            idle_all();
            tick();
        end
    endtask

    task automatic test_classic_read();
        rq[0] = '{adr: 32'he000_0000, dat: 32'h0, sel: 4'hf, we: 1'b0,
                  cti: CTI_CLASSIC, bte: 2'b00, cyc: 1'b1, stb: 1'b1};
        @(negedge clk);
        n_checks++;
        if (mcyc[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL read_latency: got cyc=%b want 0", mcyc[0]);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (mcyc[0] !== 1'b1 || mstb[0] !== 1'b1 || madr[0] !== 32'he000_0000) begin
            n_fail++;
            $display("FAIL read_grant: got cyc=%b stb=%b adr=%h want 1 1 e0000000",
                     mcyc[0], mstb[0], madr[0]);
        end
        m_ack = 1'b1;
        m_dat = 32'h1234_5678;
        #1;
        n_checks++;
        if (idat[0] !== 32'h1234_5678 || iack[0] !== 1'b1 || dack[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL read_resp: got dat=%h iack=%b dack=%b want 12345678 1 0",
                     idat[0], iack[0], dack[0]);
        end
        tick();
        idle_all();
        tick();
    endtask

    // 8-beat wrap fetch; the data bus asks at beat 2 and must wait for the end of the burst.
    task automatic test_burst();
        rq[0] = '{adr: 32'h0000_1010, dat: 32'h0, sel: 4'hf, we: 1'b0,
                  cti: CTI_INCR, bte: 2'b10, cyc: 1'b1, stb: 1'b1};
        tick();
        for (int b = 0; b < 8; b++) begin
            rq[0].adr = 32'h0000_1000 + 32'((4 + b) % 8 * 4);
            rq[0].cti = (b == 7) ? CTI_EOB : CTI_INCR;
            m_ack     = 1'b1;
            if (b == 2) begin
                rq[1] = '{adr: 32'hdddd_0000, dat: 32'h5555_aaaa, sel: 4'h3, we: 1'b1,
                          cti: CTI_CLASSIC, bte: 2'b00, cyc: 1'b1, stb: 1'b1};
            end
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (madr[k] !== rq[0].adr || mcti[k] !== rq[0].cti || iack[k] !== 1'b1
                    || dack[k] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL burst_beat dut%0d beat %0d: got adr=%h cti=%b iack=%b dack=%b want %h %b 1 0",
                             k, b, madr[k], mcti[k], iack[k], dack[k], rq[0].adr, rq[0].cti);
                end
            end
            tick();
        end
        rq[0] = '0;
        m_ack = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (mcyc[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL burst_release dut%0d: got cyc=%b want 0", k, mcyc[k]);
            end
        end
        tick();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (mcyc[k] !== 1'b1 || madr[k] !== 32'hdddd_0000 || mwe[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL burst_handover dut%0d: got cyc=%b adr=%h we=%b want 1 dddd0000 1",
                         k, mcyc[k], madr[k], mwe[k]);
            end
        end
        m_ack = 1'b1;
        tick();
        idle_all();
        tick();
    endtask

    task automatic test_stray_response();
        rq[0].stb = 1'b1;
        rq[1].stb = 1'b1;
        m_ack = 1'b1; m_err = 1'b1; m_rty = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (rsp_of(k) !== 6'd0 || mcyc[k] !== 1'b0 || mstb[k] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stray dut%0d: got rsp=%b cyc=%b stb=%b want 0 0 0",
                             k, rsp_of(k), mcyc[k], mstb[k]);
                end
            end
            tick();
        end
        idle_all();
    endtask

    // Reference: owner 0 none / 1 ifetch / 2 data; last 1 or 2. Slave answers randomly but
    // never leaves a strobe unanswered for more than two cycles.
    task automatic test_random();
        int own [2], last [2], stall [2];
        bit act [2];
        int rem [2];
        rst_n = 1'b0;
        idle_all();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            own[k] = 0; last[k] = 1; stall[k] = 0; act[k] = 0; rem[k] = 0;
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic stb_e [2];
            bit   force_ack;
            for (int w = 0; w < 2; w++) begin
                if (act[w]) begin
                    if (rem[w] == 0 || $urandom_range(0, 39) == 0) begin
                        act[w]    = 0;
                        rq[w].cyc = 1'b0;
                        rq[w].stb = 1'($urandom_range(0, 1));
                    end else begin
                        rq[w].stb = ($urandom_range(0, 3) != 0);
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    act[w] = 1;
                    rem[w] = $urandom_range(1, 4);
                    rq[w]  = '{adr: $urandom, dat: $urandom, sel: 4'($urandom),
                               we: 1'($urandom), cti: 3'($urandom), bte: 2'($urandom),
                               cyc: 1'b1, stb: 1'b1};
                end else begin
                    rq[w].adr = $urandom;
                    rq[w].stb = 1'($urandom_range(0, 1));
                end
            end
            force_ack = 0;
            for (int k = 0; k < 2; k++) begin
                int x;
                x        = (own[k] == 1) ? 0 : 1;
                stb_e[k] = (own[k] != 0) && rq[x].cyc && rq[x].stb;
                if (stb_e[k] && stall[k] >= 2) force_ack = 1;
            end
            m_dat = $urandom;
            m_ack = force_ack ? 1'b1 : 1'($urandom_range(0, 1));
            m_err = force_ack ? 1'b0 : ($urandom_range(0, 15) == 0);
            m_rty = force_ack ? 1'b0 : ($urandom_range(0, 15) == 0);
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                int          x;
                logic        cyc_e, live_i, live_d;
                logic [75:0] wbm_e;
                logic [5:0]  rsp_e;
                x      = (own[k] == 1) ? 0 : 1;
                cyc_e  = (own[k] != 0) && rq[x].cyc;
                wbm_e  = {rq[x].adr, rq[x].dat, rq[x].sel, rq[x].we, rq[x].cti, rq[x].bte,
                          cyc_e, stb_e[k]};
                live_i = (own[k] == 1) && rq[0].cyc;
                live_d = (own[k] == 2) && rq[1].cyc;
                rsp_e  = {live_i & m_ack, live_i & m_err, live_i & m_rty,
                          live_d & m_ack, live_d & m_err, live_d & m_rty};
                n_checks++;
                if (wbm_of(k) !== wbm_e) begin
                    n_fail++;
                    $display("FAIL rand_wbm dut%0d cycle %0d: got %h want %h",
                             k, cyc, wbm_of(k), wbm_e);
                end
                n_checks++;
                if (rsp_of(k) !== rsp_e || idat[k] !== m_dat || ddat[k] !== m_dat) begin
                    n_fail++;
                    $display("FAIL rand_rsp dut%0d cycle %0d: got %b %h %h want %b %h",
                             k, cyc, rsp_of(k), idat[k], ddat[k], rsp_e, m_dat);
                end
                if (rsp_e[5] || rsp_e[2]) stall[k] = 0;
                else if (stb_e[k] && !(m_ack || m_err || m_rty)) stall[k]++;
                if (k == 0) begin
                    if (rsp_e[5] && rem[0] > 0) rem[0]--;
                    if (rsp_e[2] && rem[1] > 0) rem[1]--;
                end
            end
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                int prev;
                prev = own[k];
                if (own[k] == 0) begin
                    if (rq[0].cyc && rq[1].cyc) own[k] = (k == 1 || last[k] == 1) ? 2 : 1;
                    else if (rq[0].cyc) own[k] = 1;
                    else if (rq[1].cyc) own[k] = 2;
                end else if (own[k] == 1) begin
                    last[k] = 1;
                    if (!rq[0].cyc) own[k] = rq[1].cyc ? 2 : 0;
                end else begin
                    last[k] = 2;
                    if (!rq[1].cyc) own[k] = rq[0].cyc ? 1 : 0;
                end
                if (own[k] != prev) stall[k] = 0;
            end
            #1;
        end
        idle_all();
        tick();
        tick();
    endtask

    task automatic test_reset_mid_burst();
        rq[0] = '{adr: 32'h0000_2000, dat: 32'h0, sel: 4'hf, we: 1'b0,
                  cti: CTI_INCR, bte: 2'b10, cyc: 1'b1, stb: 1'b1};
        m_ack = 1'b1;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (wbm_of(k) !== 76'd0 || rsp_of(k) !== 6'd0) begin
                n_fail++;
                $display("FAIL midburst_reset dut%0d: got wbm=%h rsp=%b want 0 0",
                         k, wbm_of(k), rsp_of(k));
            end
        end
        idle_all();
        rq[1].adr = 32'hcafe_0000;
        #1;
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (mcyc[k] !== 1'b0 || madr[k] !== 32'hcafe_0000) begin
                n_fail++;
                $display("FAIL post_reset_idle dut%0d: got cyc=%b adr=%h want 0 cafe0000",
                         k, mcyc[k], madr[k]);
            end
        end
        tick();
    endtask

`ifdef ECO32F_WB_ARB_TIMEOUT_EN
    task automatic test_timeout();
        rq[1] = '{adr: 32'h4000_0000, dat: 32'hdead_beef, sel: 4'hf, we: 1'b1,
                  cti: CTI_CLASSIC, bte: 2'b00, cyc: 1'b1, stb: 1'b1};
        tick();
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (mcyc[k] !== 1'b1 || derr[k] !== (c == 4)) begin
                    n_fail++;
                    $display("FAIL timeout_stall dut%0d cycle %0d: got cyc=%b err=%b want 1 %b",
                             k, c, mcyc[k], derr[k], c == 4);
                end
            end
            tick();
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (mcyc[k] !== 1'b0 || mstb[k] !== 1'b0 || derr[k] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL timeout_kill dut%0d: got cyc=%b stb=%b err=%b want 0 0 0",
                             k, mcyc[k], mstb[k], derr[k]);
                end
            end
            tick();
        end
        rq[1].cyc = 1'b0;
        tick();
        rq[1].cyc = 1'b1;
        tick();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (mcyc[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL timeout_regrant dut%0d: got cyc=%b want 1", k, mcyc[k]);
            end
        end
        idle_all();
        tick();
        tick();
    endtask
`else
    task automatic test_hang();
        rq[1] = '{adr: 32'h4000_0000, dat: 32'hdead_beef, sel: 4'hf, we: 1'b1,
                  cti: CTI_CLASSIC, bte: 2'b00, cyc: 1'b1, stb: 1'b1};
        tick();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (mcyc[k] !== 1'b1 || mstb[k] !== 1'b1 || derr[k] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL hang dut%0d cycle %0d: got cyc=%b stb=%b err=%b want 1 1 0",
                             k, c, mcyc[k], mstb[k], derr[k]);
                end
            end
            tick();
        end
        idle_all();
        tick();
        tick();
    endtask
`endif

    initial begin
        idle_all();
        rst_n = 1'b1;
        #3;
        test_reset();
        test_round_robin();
        test_classic_read();
        test_burst();
        test_stray_response();
        test_random();
        test_reset_mid_burst();
`ifdef ECO32F_WB_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_hang();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
